// File: rtl/stopwatch_pkg.sv
// Shared types and constants for the BCD stopwatch.
//   state_t : control FSM state (IDLE, RUN, PAUSE)
//   bcd_t   : one 4-bit BCD digit
//   SEC_LO_MOD / SEC_HI_MOD : moduli of the two seconds digits
package stopwatch_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2
    } state_t;

    typedef logic [3:0] bcd_t;

    localparam int SEC_LO_MOD = 10;
    localparam int SEC_HI_MOD = 6;

endpackage

// File: rtl/stopwatch_bcd_digit.sv
// bcd_digit: one mod-MOD BCD counter digit (MOD <= 10).
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   inc        : advance this digit by one this cycle
//   clr        : synchronous return to zero, overrides inc
//   value      : current digit value (registered)
//   carry      : inc while value is at its terminal value (MOD-1);
//                feeds the inc of the next more significant digit
module bcd_digit
    import stopwatch_pkg::*;
#(
    parameter int MOD = 10
) (
    input  logic clk,
    input  logic rst_n,
    input  logic inc,
    input  logic clr,
    output bcd_t value,
    output logic carry
);

    localparam bcd_t LAST = bcd_t'(MOD - 1);

    assign carry = inc && (value == LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            value <= '0;
        end else if (clr) begin
            value <= '0;
        end else if (inc) begin
            value <= carry ? bcd_t'(0) : bcd_t'(value + 4'd1);
        end
    end

endmodule

// File: rtl/stopwatch_bcd.sv
// stopwatch_bcd: MM:SS stopwatch counting upstream tick_en pulses in BCD.
// Optional feature: define STOPWATCH_LAP_EN to add the lap-freeze display
// (ports lap / lap_hold).
// Ports:
//   clk, rst_n  : clock, asynchronous active-low reset
//   tick_en     : one-cycle count pulse, counted only in RUN
//   start_stop  : one-cycle run/pause toggle
//   clear       : one-cycle return to zero and IDLE (highest priority)
//   digits      : {min_hi, min_lo, sec_hi, sec_lo} BCD
//   running     : high while the FSM is in RUN
//   wrap        : one-cycle pulse when the count rolls over to 00:00
//   lap         : (STOPWATCH_LAP_EN) toggles the frozen lap display in RUN
//   lap_hold    : (STOPWATCH_LAP_EN) high while digits show a frozen lap
//   state       : debug view of the control FSM state register
// Handshake: all control inputs are single-cycle pulses sampled on the
// rising edge; there is no backpressure, and a pulse that is not acted on
// in the cycle it is sampled is dropped, never queued.
module stopwatch_bcd
    import stopwatch_pkg::*;
#(
    parameter int MIN_MOD = 60
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        tick_en,
    input  logic        start_stop,
    input  logic        clear,
    output logic [15:0] digits,
    output logic        running,
    output logic        wrap,
`ifdef STOPWATCH_LAP_EN
    input  logic        lap,
    output logic        lap_hold,
`endif
    output state_t      state
);

    localparam bcd_t MIN_HI_LAST = bcd_t'((MIN_MOD - 1) / 10);
    localparam bcd_t MIN_LO_LAST = bcd_t'((MIN_MOD - 1) % 10);
    localparam int   MIN_HI_MOD  = (MIN_MOD - 1) / 10 + 1;

    state_t state_q;
    state_t state_next;

    logic count_tick;
    logic rollover;
    logic digit_clr;
    logic running_q;
    logic wrap_q;

    bcd_t sec_lo;
    bcd_t sec_hi;
    bcd_t min_lo;
    bcd_t min_hi;
    logic sec_lo_carry;
    logic sec_hi_carry;
    logic min_lo_carry;
    logic min_hi_carry;
    logic [15:0] live;

    // ---------------- control FSM ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_next;
        end
    end

    always_comb begin
        state_next = state_q;
        if (clear) begin
            state_next = IDLE;
        end else if (start_stop) begin
            case (state_q)
                IDLE:    state_next = RUN;
                RUN:     state_next = PAUSE;
                PAUSE:   state_next = RUN;
                default: state_next = IDLE;
            endcase
        end
    end

    // A tick counts only if the registered state is RUN; a simultaneous
    // start_stop out of RUN still lets this last tick through.
    assign count_tick = tick_en && (state_q == RUN) && !clear;

    // ---------------- digit chain ----------------
    // Minutes roll over at MIN_MOD-1, which need not coincide with min_hi's
    // own terminal value; the min_hi carry covers MIN_MOD multiples of ten
    // and is redundant with the explicit compare there.
    assign rollover  = (sec_hi_carry && (min_hi == MIN_HI_LAST) && (min_lo == MIN_LO_LAST))
                     || min_hi_carry;
    assign digit_clr = clear || rollover;

    bcd_digit #(.MOD(SEC_LO_MOD)) u_sec_lo (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (count_tick),
        .clr   (digit_clr),
        .value (sec_lo),
        .carry (sec_lo_carry)
    );

    bcd_digit #(.MOD(SEC_HI_MOD)) u_sec_hi (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (sec_lo_carry),
        .clr   (digit_clr),
        .value (sec_hi),
        .carry (sec_hi_carry)
    );

    bcd_digit #(.MOD(10)) u_min_lo (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (sec_hi_carry),
        .clr   (digit_clr),
        .value (min_lo),
        .carry (min_lo_carry)
    );

    bcd_digit #(.MOD(MIN_HI_MOD)) u_min_hi (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (min_lo_carry),
        .clr   (digit_clr),
        .value (min_hi),
        .carry (min_hi_carry)
    );

    assign live = {min_hi, min_lo, sec_hi, sec_lo};

    // ---------------- status outputs ----------------
    // running follows state_next so it flips on the same edge as state_q.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            running_q <= 1'b0;
            wrap_q    <= 1'b0;
        end else begin
            running_q <= (state_next == RUN);
            wrap_q    <= rollover && !clear;
        end
    end

    assign running = running_q;
    assign wrap    = wrap_q;
    assign state   = state_q;

`ifdef STOPWATCH_LAP_EN
    logic        lap_hold_q;
    logic [15:0] frozen_q;

    // The first lap snapshots the live count; the second releases it.
    // The internal count keeps running underneath either way.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lap_hold_q <= 1'b0;
            frozen_q   <= '0;
        end else if (clear) begin
            lap_hold_q <= 1'b0;
            frozen_q   <= '0;
        end else if (lap && (state_q == RUN)) begin
            lap_hold_q <= !lap_hold_q;
            if (!lap_hold_q) begin
                frozen_q <= live;
            end
        end
    end

    assign lap_hold = lap_hold_q;
    assign digits   = lap_hold_q ? frozen_q : live;
`else
    assign digits = live;
`endif

endmodule

// File: tb/tb_stopwatch_bcd.sv
module tb_stopwatch_bcd;
    import stopwatch_pkg::*;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic tick_en = 1'b0;
    logic start_stop = 1'b0;
    logic clear = 1'b0;
    logic [15:0] digits;
    logic running;
    logic wrap;
    state_t state;
`ifdef STOPWATCH_LAP_EN
    logic lap = 1'b0;
    logic lap_hold;
`endif

    always #5 clk = ~clk;

    stopwatch_bcd #(.MIN_MOD(60)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .tick_en    (tick_en),
        .start_stop (start_stop),
        .clear      (clear),
        .digits     (digits),
        .running    (running),
        .wrap       (wrap),
`ifdef STOPWATCH_LAP_EN
        .lap        (lap),
        .lap_hold   (lap_hold),
`endif
        .state      (state)
    );

    // ---------------- scoreboard ----------------
    logic [17:0] exp_q[$];   // {digits, running, wrap}
    int tests = 0;
    int fails = 0;
    int total = 0;           // reference count in seconds, mod 3600

    function automatic logic [15:0] to_bcd(input int t);
        int m;
        int s;
        m = t / 60;
        s = t % 60;
        return {4'(m / 10), 4'(m % 10), 4'(s / 10), 4'(s % 10)};
    endfunction

    function automatic logic [17:0] mk(input logic [15:0] d, input logic r, input logic w);
        return {d, r, w};
    endfunction

    task automatic compare(input string name, input logic [17:0] e);
        tests++;
        if ({digits, running, wrap} !== e) begin
            fails++;
            $display("FAIL %s: got digits=%h running=%b wrap=%b, want digits=%h running=%b wrap=%b",
                     name, digits, running, wrap, e[17:2], e[1], e[0]);
        end
    endtask

    task automatic check_state(input string name, input state_t e);
        tests++;
        if (state !== e) begin
            fails++;
            $display("FAIL %s: got state=%0d, want state=%0d", name, state, e);
        end
    endtask

    // ---------------- driver ----------------
    // Called at a falling edge: drive, let one rising edge sample, then
    // compare at the next falling edge.
    task automatic cyc(input logic ss, input logic tk, input logic cl,
                       input logic [17:0] e, input string name);
        logic [17:0] x;
        start_stop = ss;
        tick_en    = tk;
        clear      = cl;
        exp_q.push_back(e);
        @(posedge clk);
        @(negedge clk);
        start_stop = 1'b0;
        tick_en    = 1'b0;
        clear      = 1'b0;
`ifdef STOPWATCH_LAP_EN
        lap        = 1'b0;
`endif
        x = exp_q.pop_front();
        compare(name, x);
    endtask

    // Counted ticks in RUN against the reference model.
    task automatic run_ticks(input int n, input bit gaps);
        for (int i = 0; i < n; i++) begin
            if (gaps && ($urandom_range(0, 1) == 1)) begin
                cyc(1'b0, 1'b0, 1'b0, mk(to_bcd(total), 1'b1, 1'b0), "idle_gap");
            end
            total = (total + 1) % 3600;
            cyc(1'b0, 1'b1, 1'b0, mk(to_bcd(total), 1'b1, (total == 0)), "tick");
        end
    endtask

    // ---------------- vector table ----------------
    typedef struct packed {
        logic        ss;
        logic        tk;
        logic        cl;
        logic [15:0] d;
        logic        r;
    } vec_t;

    vec_t vt[18];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, want finish before 2 ms");
        $fatal(1, "watchdog");
    end

    initial begin
        // table: idle discard, start, 10 ticks, pause, discard, resume, clear
        vt[0] = '{1'b0, 1'b1, 1'b0, 16'h0000, 1'b0};  // tick in IDLE dropped
        vt[1] = '{1'b1, 1'b1, 1'b0, 16'h0000, 1'b1};  // start, tick not counted
        for (int i = 0; i < 10; i++) begin
            vt[2 + i] = '{1'b0, 1'b1, 1'b0, to_bcd(i + 1), 1'b1};
        end
        vt[12] = '{1'b1, 1'b0, 1'b0, 16'h0010, 1'b0}; // pause
        vt[13] = '{1'b0, 1'b1, 1'b0, 16'h0010, 1'b0}; // tick in PAUSE dropped
        vt[14] = '{1'b1, 1'b1, 1'b0, 16'h0010, 1'b1}; // resume, tick dropped
        vt[15] = '{1'b0, 1'b1, 1'b0, 16'h0011, 1'b1};
        vt[16] = '{1'b1, 1'b1, 1'b1, 16'h0000, 1'b0}; // clear wins
        vt[17] = '{1'b0, 1'b1, 1'b0, 16'h0000, 1'b0}; // IDLE again

        // reset state
        #12;
        compare("reset_outputs", mk(16'h0000, 1'b0, 1'b0));
        check_state("reset_state", IDLE);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 18; i++) begin
            cyc(vt[i].ss, vt[i].tk, vt[i].cl, mk(vt[i].d, vt[i].r, 1'b0), $sformatf("vec%0d", i));
        end
        check_state("after_clear_idle", IDLE);
        total = 0;

        // start_stop + tick together in RUN at 00:05
        cyc(1'b1, 1'b0, 1'b0, mk(16'h0000, 1'b1, 1'b0), "start");
        run_ticks(5, 1'b0);
        cyc(1'b1, 1'b1, 1'b0, mk(16'h0006, 1'b0, 1'b0), "stop_with_tick");
        check_state("pause_state", PAUSE);
        for (int i = 0; i < 3; i++) begin
            cyc(1'b0, 1'b1, 1'b0, mk(16'h0006, 1'b0, 1'b0), "pause_tick");
        end
        cyc(1'b0, 1'b0, 1'b1, mk(16'h0000, 1'b0, 1'b0), "clear1");
        total = 0;

        // full count to 59:59 and rollover
        cyc(1'b1, 1'b0, 1'b0, mk(16'h0000, 1'b1, 1'b0), "start2");
        run_ticks(3599, 1'b1);
        compare("at_5959", mk(16'h5959, 1'b1, 1'b0));
        run_ticks(1, 1'b0);                       // expects 0000 with wrap=1
        cyc(1'b0, 1'b0, 1'b0, mk(16'h0000, 1'b1, 1'b0), "wrap_one_cycle");
        run_ticks(1, 1'b0);

        // clear + start_stop + tick together at 12:34
        cyc(1'b0, 1'b0, 1'b1, mk(16'h0000, 1'b0, 1'b0), "clear2");
        total = 0;
        cyc(1'b1, 1'b0, 1'b0, mk(16'h0000, 1'b1, 1'b0), "start3");
        run_ticks(754, 1'b0);
        compare("at_1234", mk(16'h1234, 1'b1, 1'b0));
        cyc(1'b1, 1'b1, 1'b1, mk(16'h0000, 1'b0, 1'b0), "clear_prio");
        check_state("clear_prio_state", IDLE);
        total = 0;

        // asynchronous reset mid-cycle at 03:07
        cyc(1'b1, 1'b0, 1'b0, mk(16'h0000, 1'b1, 1'b0), "start4");
        run_ticks(187, 1'b0);
        compare("at_0307", mk(16'h0307, 1'b1, 1'b0));
        #2;
        rst_n = 1'b0;
        #1;
        compare("async_reset", mk(16'h0000, 1'b0, 1'b0));
        check_state("async_reset_state", IDLE);
        @(negedge clk);
        rst_n = 1'b1;
        total = 0;
        cyc(1'b0, 1'b1, 1'b0, mk(16'h0000, 1'b0, 1'b0), "post_reset_idle0");
        cyc(1'b0, 1'b1, 1'b0, mk(16'h0000, 1'b0, 1'b0), "post_reset_idle1");
        cyc(1'b1, 1'b0, 1'b0, mk(16'h0000, 1'b1, 1'b0), "start5");
        run_ticks(2, 1'b0);

`ifdef STOPWATCH_LAP_EN
        // lap freeze and release
        cyc(1'b0, 1'b0, 1'b1, mk(16'h0000, 1'b0, 1'b0), "clear_lap");
        total = 0;
        cyc(1'b1, 1'b0, 1'b0, mk(16'h0000, 1'b1, 1'b0), "start_lap");
        run_ticks(20, 1'b0);
        lap = 1'b1;
        cyc(1'b0, 1'b0, 1'b0, mk(16'h0020, 1'b1, 1'b0), "lap_freeze");
        tests++;
        if (lap_hold !== 1'b1) begin
            fails++;
            $display("FAIL lap_hold_set: got %b, want 1", lap_hold);
        end
        for (int i = 0; i < 5; i++) begin
            total = total + 1;
            cyc(1'b0, 1'b1, 1'b0, mk(16'h0020, 1'b1, 1'b0), "lap_frozen_tick");
        end
        lap = 1'b1;
        cyc(1'b0, 1'b0, 1'b0, mk(16'h0025, 1'b1, 1'b0), "lap_release");
        tests++;
        if (lap_hold !== 1'b0) begin
            fails++;
            $display("FAIL lap_hold_clr: got %b, want 0", lap_hold);
        end
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
